// File: rtl/vreg_pkg.sv
// Shared constants, types and window-decode helper for the vector register scoreboard.
// The helper is width-agnostic so that overridden VBASE/NVREG still decode correctly.
package vreg_pkg;

  localparam int VREG_ADDR_W = 5;
  localparam int VREG_VBASE  = 16;
  localparam int VREG_NVREG  = 8;
  localparam int VREG_IDX_W  = $clog2(VREG_NVREG);

  typedef logic [VREG_IDX_W-1:0] vreg_idx_t;

  typedef struct packed {
    logic        vec;
    logic [31:0] off;
  } vreg_win_t;

  // Offset is forced to zero outside the window so callers never see a stray index.
  function automatic vreg_win_t in_window(input logic [31:0] addr,
                                          input int unsigned base,
                                          input int unsigned n);
    vreg_win_t w;
    w.vec = (addr >= base) && (addr < base + n);
    w.off = w.vec ? (addr - base) : 32'd0;
    return w;
  endfunction

endpackage

// File: rtl/vreg_addr_map.sv
// Combinational translation of one architectural register number into the vector window.
module vreg_addr_map
  import vreg_pkg::*;
#(
  parameter int ADDR_W = VREG_ADDR_W,
  parameter int VBASE  = VREG_VBASE,
  parameter int NVREG  = VREG_NVREG,
  parameter int IDX_W  = $clog2(NVREG)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              vec,
  output logic [IDX_W-1:0]  idx
);

  vreg_win_t win;
  logic      unused_off_hi;

  assign win = in_window(32'(addr), VBASE, NVREG);
  assign vec = win.vec;
  assign idx = win.off[IDX_W-1:0];
  // Upper offset bits are always zero inside the window.
  assign unused_off_hi = ^win.off[31:IDX_W];

endmodule

// File: rtl/vreg_scoreboard.sv
// Vector register scoreboard: address translation, per-register busy bits,
// outstanding-write counter and RAW/WAW/full issue stall.
module vreg_scoreboard
  import vreg_pkg::*;
#(
  parameter int ADDR_W       = VREG_ADDR_W,
  parameter int VBASE        = VREG_VBASE,
  parameter int NVREG        = VREG_NVREG,
  parameter int MAX_INFLIGHT = 4,
  localparam int IDX_W       = $clog2(NVREG),
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              issue_valid,
  input  logic              rd_write,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic              flush,
  output logic [IDX_W-1:0]  rs1_idx,
  output logic [IDX_W-1:0]  rs2_idx,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              rs1_vec,
  output logic              rs2_vec,
  output logic              rd_vec,
  output logic              stall,
  output logic              issue_fire,
  output logic [NVREG-1:0]  busy,
  output logic [CNT_W-1:0]  inflight,
  output logic              err_wb
);

  logic [NVREG-1:0] busy_reg, busy_next;
  logic [CNT_W-1:0] inflight_reg, inflight_next;
  logic             err_wb_reg, err_wb_next;

  logic raw, waw, full;
  logic set, clr, clr_eff, clr_bad;

  vreg_addr_map #(.ADDR_W(ADDR_W), .VBASE(VBASE), .NVREG(NVREG), .IDX_W(IDX_W)) u_map_rs1 (
    .addr (rs1),
    .vec  (rs1_vec),
    .idx  (rs1_idx)
  );

  vreg_addr_map #(.ADDR_W(ADDR_W), .VBASE(VBASE), .NVREG(NVREG), .IDX_W(IDX_W)) u_map_rs2 (
    .addr (rs2),
    .vec  (rs2_vec),
    .idx  (rs2_idx)
  );

  vreg_addr_map #(.ADDR_W(ADDR_W), .VBASE(VBASE), .NVREG(NVREG), .IDX_W(IDX_W)) u_map_rd (
    .addr (rd),
    .vec  (rd_vec),
    .idx  (rd_idx)
  );

  // Hazards look only at registered busy; a same-cycle writeback does not bypass.
  assign raw  = (rs1_vec & busy_reg[rs1_idx]) | (rs2_vec & busy_reg[rs2_idx]);
  assign waw  = rd_write & rd_vec & busy_reg[rd_idx];
  assign full = rd_write & rd_vec & (inflight_reg == CNT_W'(MAX_INFLIGHT));

  assign stall      = issue_valid & (raw | waw | full) & ~flush;
  assign issue_fire = issue_valid & ~stall;

  assign set     = issue_fire & rd_write & rd_vec & ~flush;
  assign clr     = wb_valid & ~flush;
  assign clr_eff = clr & busy_reg[wb_idx];
  assign clr_bad = clr & ~busy_reg[wb_idx];

  // Set is applied after clear, so a same-index set+clear leaves the bit busy.
  for (genvar gi = 0; gi < NVREG; gi++) begin : g_busy
    always_comb begin
      busy_next[gi] = busy_reg[gi];
      if (clr_eff && (wb_idx == IDX_W'(gi))) busy_next[gi] = 1'b0;
      if (set && (rd_idx == IDX_W'(gi)))     busy_next[gi] = 1'b1;
      if (flush)                             busy_next[gi] = 1'b0;
    end
  end

  always_comb begin
    inflight_next = inflight_reg;
    if (flush) begin
      inflight_next = '0;
    end else if (set && !clr_eff) begin
      if (inflight_reg != CNT_W'(MAX_INFLIGHT)) inflight_next = inflight_reg + CNT_W'(1);
    end else if (clr_eff && !set) begin
      if (inflight_reg != '0) inflight_next = inflight_reg - CNT_W'(1);
    end
  end

  assign err_wb_next = err_wb_reg | clr_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg     <= '0;
      inflight_reg <= '0;
      err_wb_reg   <= 1'b0;
    end else begin
      busy_reg     <= busy_next;
      inflight_reg <= inflight_next;
      err_wb_reg   <= err_wb_next;
    end
  end

  assign busy     = busy_reg;
  assign inflight = inflight_reg;
  assign err_wb   = err_wb_reg;

endmodule

// File: tb/tb_vreg_scoreboard.sv
// Directed self-checking bench for vreg_scoreboard with default parameters.
module tb_vreg_scoreboard;

  logic       clk;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       issue_valid, rd_write, wb_valid, flush;
  logic [2:0] wb_idx;
  logic [2:0] rs1_idx, rs2_idx, rd_idx;
  logic       rs1_vec, rs2_vec, rd_vec;
  logic       stall, issue_fire, err_wb;
  logic [7:0] busy;
  logic [2:0] inflight;

  int total = 0;
  int bad   = 0;

  vreg_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .issue_valid (issue_valid),
    .rd_write    (rd_write),
    .wb_valid    (wb_valid),
    .wb_idx      (wb_idx),
    .flush       (flush),
    .rs1_idx     (rs1_idx),
    .rs2_idx     (rs2_idx),
    .rd_idx      (rd_idx),
    .rs1_vec     (rs1_vec),
    .rs2_vec     (rs2_vec),
    .rd_vec      (rd_vec),
    .stall       (stall),
    .issue_fire  (issue_fire),
    .busy        (busy),
    .inflight    (inflight),
    .err_wb      (err_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    issue_valid = 1'b0; rd_write = 1'b0;
    wb_valid = 1'b0; wb_idx = 3'd0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [4:0] r);
    clear_in();
    issue_valid = 1'b1; rd_write = 1'b1; rd = r;
    tick();
  endtask

  task automatic chk_state(input string tag, input logic [7:0] b, input logic [2:0] n, input logic e);
    chk({tag, ".busy"}, {24'd0, busy}, {24'd0, b});
    chk({tag, ".inflight"}, {29'd0, inflight}, {29'd0, n});
    chk({tag, ".err_wb"}, {31'd0, err_wb}, {31'd0, e});
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state and idle issue
    chk_state("reset", 8'h00, 3'd0, 1'b0);
    issue_valid = 1'b1; #1;
    chk("reset.stall", {31'd0, stall}, 32'd0);
    chk("reset.fire", {31'd0, issue_fire}, 32'd1);

    // Translation boundaries
    clear_in(); rs1 = 5'd23; rs2 = 5'd24; rd = 5'd15; #1;
    chk("map23.vec", {31'd0, rs1_vec}, 32'd1);
    chk("map23.idx", {29'd0, rs1_idx}, 32'd7);
    chk("map24.vec", {31'd0, rs2_vec}, 32'd0);
    chk("map24.idx", {29'd0, rs2_idx}, 32'd0);
    chk("map15.vec", {31'd0, rd_vec}, 32'd0);
    chk("map15.idx", {29'd0, rd_idx}, 32'd0);
    rs1 = 5'd16; #1;
    chk("map16.idx", {29'd0, rs1_idx}, 32'd0);
    chk("map16.vec", {31'd0, rs1_vec}, 32'd1);

    // Issue rd=17
    clear_in(); issue_valid = 1'b1; rd_write = 1'b1; rd = 5'd17; #1;
    chk("wr17.rd_idx", {29'd0, rd_idx}, 32'd1);
    chk("wr17.fire", {31'd0, issue_fire}, 32'd1);
    tick(); clear_in();
    chk_state("wr17", 8'h02, 3'd1, 1'b0);

    // RAW stall, writeback in the same cycle does not bypass
    issue_valid = 1'b1; rs1 = 5'd17; #1;
    chk("raw.stall", {31'd0, stall}, 32'd1);
    chk("raw.fire", {31'd0, issue_fire}, 32'd0);
    wb_valid = 1'b1; wb_idx = 3'd1; #1;
    chk("raw_wb.stall", {31'd0, stall}, 32'd1);
    tick(); clear_in();
    chk_state("wb1", 8'h00, 3'd0, 1'b0);
    issue_valid = 1'b1; rs1 = 5'd17; #1;
    chk("reissue.stall", {31'd0, stall}, 32'd0);
    chk("reissue.fire", {31'd0, issue_fire}, 32'd1);

    // WAW, RAW with scalar rd, scalar-only operands
    issue_wr(5'd17);
    chk_state("wr17b", 8'h02, 3'd1, 1'b0);
    clear_in(); issue_valid = 1'b1; rd_write = 1'b1; rd = 5'd17; #1;
    chk("waw.stall", {31'd0, stall}, 32'd1);
    rd = 5'd5; rs1 = 5'd17; #1;
    chk("raw_scalar_rd.stall", {31'd0, stall}, 32'd1);
    rd = 5'd0; rd_write = 1'b0; rs1 = 5'd5; rs2 = 5'd30; #1;
    chk("scalar.rs1_vec", {31'd0, rs1_vec}, 32'd0);
    chk("scalar.rs2_vec", {31'd0, rs2_vec}, 32'd0);
    chk("scalar.rs2_idx", {29'd0, rs2_idx}, 32'd0);
    chk("scalar.stall", {31'd0, stall}, 32'd0);
    tick();
    chk_state("scalar", 8'h02, 3'd1, 1'b0);
    clear_in(); wb_valid = 1'b1; wb_idx = 3'd1;
    tick(); clear_in();
    chk_state("drain", 8'h00, 3'd0, 1'b0);

    // Inflight limit
    issue_wr(5'd16); issue_wr(5'd17); issue_wr(5'd18); issue_wr(5'd19);
    clear_in();
    chk_state("fill", 8'h0F, 3'd4, 1'b0);
    issue_valid = 1'b1; rd_write = 1'b1; rd = 5'd5; #1;
    chk("full_scalar.stall", {31'd0, stall}, 32'd0);
    rd = 5'd20; wb_valid = 1'b1; wb_idx = 3'd0; #1;
    chk("full.stall", {31'd0, stall}, 32'd1);
    chk("full.fire", {31'd0, issue_fire}, 32'd0);
    tick();
    chk_state("full_wb", 8'h0E, 3'd3, 1'b0);
    wb_valid = 1'b0; #1;
    chk("after_full.fire", {31'd0, issue_fire}, 32'd1);
    tick(); clear_in();
    chk_state("after_full", 8'h1E, 3'd4, 1'b0);

    flush = 1'b1;
    tick(); clear_in();
    chk_state("flush1", 8'h00, 3'd0, 1'b0);

    // Writeback to idle register is an error, sticky
    wb_valid = 1'b1; wb_idx = 3'd3;
    tick(); clear_in();
    chk_state("err", 8'h00, 3'd0, 1'b1);
    tick();
    chk_state("err_sticky", 8'h00, 3'd0, 1'b1);
    issue_valid = 1'b1; rd_write = 1'b1; rd = 5'd19; wb_valid = 1'b1; wb_idx = 3'd3;
    tick(); clear_in();
    chk_state("setclr", 8'h08, 3'd1, 1'b1);

    // Flush overrides set/clear and stall; err_wb kept
    issue_wr(5'd16); issue_wr(5'd17); issue_wr(5'd18);
    clear_in();
    chk_state("prefl", 8'h0F, 3'd4, 1'b1);
    flush = 1'b1; issue_valid = 1'b1; rd_write = 1'b1; rd = 5'd22; rs1 = 5'd16;
    wb_valid = 1'b1; wb_idx = 3'd0; #1;
    chk("flush.stall", {31'd0, stall}, 32'd0);
    chk("flush.fire", {31'd0, issue_fire}, 32'd1);
    tick(); clear_in();
    chk_state("flush2", 8'h00, 3'd0, 1'b1);

    // Reset beats everything
    issue_wr(5'd17);
    clear_in();
    chk_state("prerst", 8'h02, 3'd1, 1'b1);
    rst = 1'b1; issue_valid = 1'b1; rd_write = 1'b1; rd = 5'd18; wb_valid = 1'b1; wb_idx = 3'd5;
    tick(); rst = 1'b0; clear_in();
    chk_state("rst", 8'h00, 3'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
